lfsr: RTL and testbench

Seeded pseudo-random bit generator with serial output. After reset it loads a seed and advances a Fibonacci LFSR for a fixed number of cycles. It then shifts the resulting register contents out one bit per clock, LSB first, with a qualifying `Valid` strobe. It sits as a leaf block feeding serial consumers (scramblers, test-pattern sinks) and needs re-reset to produce a new word.

---
 rtl/lfsr_if.sv | 10 +
 rtl/lfsr.sv | 57 +++++
 tb/tb_lfsr.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lfsr_if.sv
// lfsr_if: seed input and serial data/valid outputs of the lfsr block
interface lfsr_if #(
  parameter int N = 4
);
  logic [N-1:0] Seed;
  logic         OUT;
  logic         Valid;
  modport master (output Seed, input OUT, Valid);
  modport slave  (input Seed, output OUT, Valid);
endinterface

// File: rtl/lfsr.sv
// lfsr: seeded Fibonacci LFSR that advances Gen_cycles times, then shifts its word out LSB first
module lfsr #(
  parameter int                    Shift_bits = 4,
  parameter logic [Shift_bits-1:0] Taps       = 'b0011,
  parameter int                    Gen_cycles = 16
) (
  input  logic  CLK,
  input  logic  RST,
  lfsr_if.slave bus
);
  localparam int N    = Shift_bits;
  localparam int MaxC = Gen_cycles > N ? Gen_cycles : N;
  localparam int CW   = $clog2(MaxC + 1);
  typedef enum logic [1:0] {GEN, SHIFT, DONE} state_e;
  state_e        state_q, state_d;
  logic [N-1:0]  lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d, valid_q, valid_d, fb, last;
  always_comb begin
    fb      = ^(lfsr_q & Taps);
    last    = cnt_q == (state_q == GEN ? CW'(Gen_cycles - 1) : CW'(N - 1));
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    valid_d = 1'b0;
    if (state_q == GEN) begin
      lfsr_d  = {fb, lfsr_q[N-1:1]};
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? SHIFT : GEN;
    end else if (state_q == SHIFT) begin
      out_d   = lfsr_q[0];
      valid_d = 1'b1;
      lfsr_d  = {1'b0, lfsr_q[N-1:1]};
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      state_d = last ? DONE : SHIFT;
    end
  end
  // an all-zero seed would lock the register, so it loads all-ones instead
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q  <= bus.Seed == '0 ? '1 : bus.Seed;
      state_q <= GEN;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
  assign bus.OUT   = out_q;
  assign bus.Valid = valid_q;
endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: checks generated words against an arithmetic LFSR model for two Gen_cycles settings
module tb_lfsr;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] seed;
  int         sel;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       out_s, val_s;
  always #5 clk = ~clk;
  lfsr_if #(.N(4)) a ();
  lfsr_if #(.N(4)) b ();
  assign a.Seed = seed;
  assign b.Seed = seed;
  lfsr u_a (.CLK(clk), .RST(rst), .bus(a.slave));
  lfsr #(.Gen_cycles(1)) u_b (.CLK(clk), .RST(rst), .bus(b.slave));
  assign out_s = sel != 0 ? b.OUT : a.OUT;
  assign val_s = sel != 0 ? b.Valid : a.Valid;

  typedef struct {
    logic [3:0] seed;
    logic [3:0] word;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] s);
    rst  = 1'b1;
    seed = s;
    step();
    rst  = 1'b0;
  endtask

  function automatic logic [3:0] model(input logic [3:0] s, input int gens);
    int r  = s == 4'd0 ? 15 : int'(s);
    int fb;
    for (int i = 0; i < gens; i++) begin
      fb = $countones(r & 3) % 2;
      r  = (r / 2) + fb * 8;
    end
    return 4'(r);
  endfunction

  task automatic run_word(input int s_sel, input logic [3:0] exp, input string nm, input bit scramble);
    int         gens   = s_sel != 0 ? 1 : 16;
    int         noisy  = 0;
    int         vcount = 0;
    logic [3:0] w      = '0;
    sel = s_sel;
    for (int e = 0; e < gens; e++) begin
      if (scramble) seed = 4'($urandom);
      step();
      if (out_s !== 1'b0 || val_s !== 1'b0) noisy++;
    end
    for (int i = 0; i < 4; i++) begin
      if (scramble) seed = 4'($urandom);
      step();
      if (val_s === 1'b1) vcount++;
      w[i] = out_s;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_s !== 1'b0 || val_s !== 1'b0) noisy++;
    end
    check({nm, "_quiet"}, noisy, 0);
    check({nm, "_word"}, {28'd0, w}, {28'd0, exp});
    check({nm, "_valid_len"}, vcount, 4);
  endtask

  initial begin
    int bad;
    logic [3:0] s;
    tbl[0] = '{4'b1001, 4'b1100};
    tbl[1] = '{4'b0000, 4'b0111};
    tbl[2] = '{4'b0001, 4'b1000};
    tbl[3] = '{4'b1111, 4'b0111};
    tbl[4] = '{4'b0010, 4'b1001};
    rst  = 1'b1;
    seed = 4'b1001;
    sel  = 0;
    bad  = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a.OUT !== 1'b0 || a.Valid !== 1'b0 || b.OUT !== 1'b0 || b.Valid !== 1'b0) bad++;
    end
    check("rst_held_outputs", bad, 0);
    rst = 1'b0;
    run_word(0, 4'b1100, "first_after_hold", 0);
    for (int i = 0; i < 5; i++) begin
      do_reset(tbl[i].seed);
      run_word(0, tbl[i].word, $sformatf("tbl%0d", i), 0);
    end
    do_reset(4'b1001);
    sel = 0;
    for (int i = 0; i < 17; i++) step();
    check("mid_first_bit", {30'd0, val_s, out_s}, 32'd2);
    rst = 1'b1;
    step();
    check("mid_reset_valid", {30'd0, val_s, out_s}, 32'd0);
    rst = 1'b0;
    run_word(0, 4'b1100, "mid_restart", 0);
    do_reset(4'b1001);
    run_word(1, 4'b1100, "gen1", 0);
    do_reset(4'b0000);
    run_word(1, model(4'b0000, 1), "gen1_zero", 0);
    do_reset(4'b1001);
    run_word(0, 4'b1100, "seed_noise", 1);
    for (int i = 0; i < 16; i++) begin
      s = 4'($urandom);
      do_reset(s);
      run_word(i % 2, model(s, i % 2 != 0 ? 1 : 16), $sformatf("rand%0d_s%0h", i, s), i % 4 == 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
